// File: rtl/mdu_div_sequencer.sv
// ============================================================================
// Module : mdu_div_sequencer
// Brief  : Iterative restoring divider/sequencer for DIV, DIVU, REM, REMU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_div_sequencer #(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       FUNCT3,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic             BUSY,
  output logic             VALID,
  output logic [WIDTH-1:0] RESULT
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST   = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             is_rem_q, is_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic             op_signed, op_rem, sign1, sign2;
  logic             div_zero, overflow, accept;
  logic [WIDTH-1:0] abs1, abs2, quot_fix, rem_fix;
  logic [WIDTH+1:0] trial;
  logic             trial_ge;

  always_comb begin
    op_signed = FUNCT3[2] & ~FUNCT3[0];
    op_rem    = FUNCT3[2] & FUNCT3[1];
    sign1     = op_signed & DATA1[WIDTH-1];
    sign2     = op_signed & DATA2[WIDTH-1];
    abs1      = sign1 ? ('0 - DATA1) : DATA1;
    abs2      = sign2 ? ('0 - DATA2) : DATA2;
    div_zero  = (DATA2 == '0);
    overflow  = op_signed & (DATA1 == C_MIN) & (&DATA2);
    accept    = START & ((state_q == S_IDLE) | (state_q == S_DONE));

    // Shift in the next dividend bit, then trial-subtract with a spare sign bit.
    trial     = {rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
    trial_ge  = ~trial[WIDTH+1];

    quot_fix  = q_neg_q ? ('0 - dvd_q) : dvd_q;
    rem_fix   = r_neg_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    state_d   = state_q;
    count_d   = count_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    is_rem_d  = is_rem_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          dvd_d    = abs1;
          dvs_d    = abs2;
          rem_d    = '0;
          count_d  = '0;
          // Divide-by-zero keeps an all-ones quotient even for a negative dividend.
          q_neg_d  = (sign1 ^ sign2) & ~div_zero;
          r_neg_d  = sign1;
          is_rem_d = op_rem;
          if (FAST_SPECIAL && (div_zero || overflow)) begin
            if (div_zero) result_d = op_rem ? DATA1 : '1;
            else          result_d = op_rem ? '0 : C_MIN;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = trial_ge ? trial[WIDTH:0] : {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        dvd_d = {dvd_q[WIDTH-2:0], trial_ge};
        if (count_q == C_LAST) state_d = S_FIX;
        else                   count_d = count_q + 1'b1;
      end
      S_FIX: begin
        result_d = is_rem_q ? rem_fix : quot_fix;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (FLUSH) begin
      state_d  = S_IDLE;
      count_d  = '0;
      result_d = result_q;
    end

    valid_d = (state_d == S_DONE);
    busy_d  = (state_d == S_CALC) | (state_d == S_FIX);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign BUSY   = busy_q;
  assign VALID  = valid_q;
  assign RESULT = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_div_sequencer.sv
// ============================================================================
// Module : tb_mdu_div_sequencer
// Brief  : Directed scoreboard bench for the RV32M divide sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        FLUSH = 1'b0;
  logic        BUSY;
  logic        VALID;
  logic [31:0] RESULT;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  mdu_div_sequencer #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every VALID pulse pops one expected result.
  always @(negedge CLK) begin
    if (RESET && VALID) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%h expected=none", RESULT);
      end else begin
        check("result", RESULT, exp_q.pop_front());
      end
      check("busy_in_valid", 32'(BUSY), 32'd0);
    end
  end

  task automatic wait_valid(input string name, input int exp_lat, input int exp_busy);
    int  n = 0;
    int  nb = 0;
    bit  seen = 0;
    while (!seen && n < 100) begin
      @(negedge CLK);
      n++;
      if (n == 1) START = 1'b0;
      if (BUSY) nb++;
      if (VALID) seen = 1;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input int lat, input int nb);
    FUNCT3 = f3;
    DATA1  = a;
    DATA2  = b;
    START  = 1'b1;
    exp_q.push_back(e);
    last_exp = e;
    wait_valid(name, lat, nb);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int nv = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (VALID) nv++;
    end
    check(name, 32'(nv), 32'd0);
  endtask

  initial begin
    #1 RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_valid", 32'(VALID), 32'd0);
    check("reset_result", RESULT, 32'd0);
    RESET = 1'b1;

    // Issued on the same negedge as reset release: first edge must accept.
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34, 33);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 34, 33);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 33);
    run_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33);
    run_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 33);
    run_op("f3_000_divu", 3'b000, 32'd100, 32'd7, 32'd14, 34, 33);
    run_op("div_5_0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0",   3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("rem_m8_0",   3'b110, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 1, 0);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 33);
    @(negedge CLK);

    // Flush mid-operation: no result, RESULT holds.
    FUNCT3 = 3'b101; DATA1 = 32'd1000; DATA2 = 32'd10; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy", 32'(BUSY), 32'd0);
    expect_quiet("flush_no_valid", 40);
    check("flush_result_held", RESULT, last_exp);
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 34, 33);
    @(negedge CLK);

    // Back-to-back with an ignored START pulse while busy.
    FUNCT3 = 3'b101; DATA1 = 32'd50; DATA2 = 32'd5; START = 1'b1;
    exp_q.push_back(32'd10);
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    DATA1 = 32'd81; DATA2 = 32'd9; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (27) @(negedge CLK);
    DATA1 = 32'd81; DATA2 = 32'd9; START = 1'b1;
    exp_q.push_back(32'd9);
    @(negedge CLK);
    check("b2b_first_valid", 32'(VALID), 32'd1);
    @(negedge CLK);
    START = 1'b0;
    check("b2b_busy_after_accept", 32'(BUSY), 32'd1);
    wait_valid("b2b_second", 33, 32);
    @(negedge CLK);

    // Asynchronous reset mid-operation.
    FUNCT3 = 3'b101; DATA1 = 32'd1000; DATA2 = 32'd7; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (14) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async_rst_busy", 32'(BUSY), 32'd0);
    check("async_rst_valid", 32'(VALID), 32'd0);
    check("async_rst_result", RESULT, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    expect_quiet("post_reset_no_valid", 40);
    run_op("post_reset_divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 33);
    repeat (3) @(negedge CLK);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
